bvurem_ic_checker: RTL and testbench

Sequential checker that evaluates the unsigned remainder `x urem s` for W-bit operands and compares it against a target `t`. It is the consumer end of the synthesized Skolem witness blocks: a generated witness `x` is fed in together with `s` and `t`, and the block reports whether the witness satisfies `x urem s == t` with SMT-LIB semantics. It sits between the witness generators and the result scoreboard. It uses a bit-serial restoring divider and ready/valid handshakes on both sides.

---
 rtl/bvurem_ic_checker_pkg.sv | 16 +
 rtl/bvurem_ic_checker_if.sv | 27 ++
 rtl/bvurem_ic_checker_urem_step.sv | 27 ++
 rtl/bvurem_ic_checker.sv | 107 ++++++++++
 tb/tb_bvurem_ic_checker.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/bvurem_ic_checker_pkg.sv
// Shared types for the bit-serial urem checker: controller states and the
// helper that sizes the restoring-step counter.
package bvurem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter only has to reach W-1, so it needs $clog2(W) bits (W >= 2).
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/bvurem_ic_checker_if.sv
// Operand and result handshake bundle between the witness generators, the
// checker and the result scoreboard.
interface bvurem_ic_checker_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_s;
    logic [W-1:0] in_t;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_rem;
    logic [W-1:0] out_quo;
    logic         out_match;
    logic         out_zero;

    modport master (
        output in_valid, in_x, in_s, in_t, out_ready,
        input  in_ready, out_valid, out_rem, out_quo, out_match, out_zero
    );

    modport slave (
        input  in_valid, in_x, in_s, in_t, out_ready,
        output in_ready, out_valid, out_rem, out_quo, out_match, out_zero
    );
endinterface

// File: rtl/bvurem_ic_checker_urem_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module urem_step #(
    parameter int W = 4
) (
    input  logic [W:0]   i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_s,
    output logic [W:0]   o_rem,
    output logic         o_qbit
);
    logic [W+1:0] w_p;
    logic [W+1:0] w_s_ext;

    // i_rem[W] is always 0 because rem < s, so the extra top bit is harmless.
    assign w_p     = {i_rem, i_bit};
    assign w_s_ext = {2'b00, i_s};

    always_comb begin
        o_qbit = 1'b0;
        o_rem  = (W+1)'(w_p);
        if (w_p >= w_s_ext) begin
            o_qbit = 1'b1;
            o_rem  = (W+1)'(w_p - w_s_ext);
        end
    end
endmodule

// File: rtl/bvurem_ic_checker.sv
// Bit-serial checker: computes x urem s / x udiv s with SMT-LIB semantics and
// flags whether the remainder equals the target t.
module bvurem_ic_checker
    import bvurem_pkg::*;
#(
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bvurem_ic_checker_if.slave bus
);
    localparam int CW = cnt_width(W);

    state_t        r_state;
    logic [W:0]    r_rem;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_s;
    logic [W-1:0]  r_t;
    logic [CW-1:0] r_cnt;
    logic          r_out_valid;
    logic [W-1:0]  r_out_rem;
    logic [W-1:0]  r_out_quo;
    logic          r_out_match;
    logic          r_out_zero;

    logic [W:0]    w_rem;
    logic          w_qbit;
    logic [W-1:0]  w_quo_next;

    urem_step #(.W(W)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_q[W-1]),
        .i_s    (r_s),
        .o_rem  (w_rem),
        .o_qbit (w_qbit)
    );

    assign w_quo_next = {r_q[W-2:0], w_qbit};

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_s         <= '0;
            r_t         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_rem   <= '0;
            r_out_quo   <= '0;
            r_out_match <= 1'b0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_s <= bus.in_s;
                        r_t <= bus.in_t;
                        if (bus.in_s == '0) begin
                            // Division by zero: rem = x, quo = all-ones.
                            r_out_rem   <= bus.in_x;
                            r_out_quo   <= '1;
                            r_out_match <= (bus.in_x == bus.in_t);
                            r_out_zero  <= (bus.in_x == '0);
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_rem   <= '0;
                            r_q     <= bus.in_x;
                            r_cnt   <= '0;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem;
                    r_q   <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(W-1)) begin
                        r_out_rem   <= w_rem[W-1:0];
                        r_out_quo   <= w_quo_next;
                        r_out_match <= (w_rem[W-1:0] == r_t);
                        r_out_zero  <= (w_rem[W-1:0] == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_rem   = r_out_rem;
    assign bus.out_quo   = r_out_quo;
    assign bus.out_match = r_out_match;
    assign bus.out_zero  = r_out_zero;
endmodule

// File: tb/tb_bvurem_ic_checker.sv
// Self-checking bench for bvurem_ic_checker: directed scenarios plus an
// exhaustive W=4 sweep against an arithmetic urem/udiv reference.
module tb_bvurem_ic_checker;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    bvurem_ic_checker_if #(.W(W)) bus ();

    bvurem_ic_checker #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: SMT-LIB urem/udiv, division by zero gives x and all-ones.
    function automatic void model(input int x, input int s, input int t,
                                  output int r, output int q,
                                  output bit m, output bit z);
        if (s == 0) begin
            r = x;
            q = (1 << W) - 1;
        end else begin
            r = x % s;
            q = x / s;
        end
        m = (r == t);
        z = (r == 0);
    endfunction

    // Drives one bundle, waits for the result, stalls, then consumes it.
    task automatic run_txn(input int x, input int s, input int t, input int stall,
                           output bit got, output int lat,
                           output int rem, output int quo,
                           output bit m, output bit z,
                           output bit busy_ok, output bit held_ok,
                           output bit after_ok);
        int g;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            tick();
            g++;
        end
        bus.in_x     = W'(x);
        bus.in_s     = W'(s);
        bus.in_t     = W'(t);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_x     = W'($urandom);
        bus.in_s     = W'($urandom);
        bus.in_t     = W'($urandom);
        lat     = 1;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        after_ok = 1'b1;
        while (!bus.out_valid && lat < W + 10) begin
            if (bus.in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        got = bus.out_valid;
        rem = int'(bus.out_rem);
        quo = int'(bus.out_quo);
        m   = bus.out_match;
        z   = bus.out_zero;
        if (!got) return;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_x     = W'($urandom);
            bus.in_s     = W'($urandom);
            tick();
            if (bus.in_ready || !bus.out_valid || int'(bus.out_rem) != rem ||
                int'(bus.out_quo) != quo || bus.out_match != m || bus.out_zero != z)
                held_ok = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        if (bus.out_valid || !bus.in_ready) after_ok = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if ({bus.out_rem, bus.out_quo, bus.out_match, bus.out_zero} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rem=%0d quo=%0d match=%b zero=%b want all 0",
                     bus.out_rem, bus.out_quo, bus.out_match, bus.out_zero);
        end
    endtask

    // Directed case with an explicit expected result and latency.
    task automatic test_directed(input string name, input int x, input int s, input int t,
                                 input int stall, input int e_rem, input int e_quo,
                                 input bit e_m, input bit e_z, input int e_lat);
        bit got, m, z, b_ok, h_ok, a_ok;
        int lat, rem, quo;
        run_txn(x, s, t, stall, got, lat, rem, quo, m, z, b_ok, h_ok, a_ok);
        n_cmp++;
        if (!got || lat != e_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, lat, got, e_lat);
        end
        n_cmp++;
        if (rem != e_rem || quo != e_quo || m != e_m || z != e_z) begin
            n_err++;
            $display("FAIL %s result: got rem=%0d quo=%0d match=%b zero=%b want %0d %0d %b %b",
                     name, rem, quo, m, z, e_rem, e_quo, e_m, e_z);
        end
        n_cmp++;
        if (!b_ok || !h_ok || !a_ok) begin
            n_err++;
            $display("FAIL %s handshake: busy_ok=%b held_ok=%b after_ok=%b want 111",
                     name, b_ok, h_ok, a_ok);
        end
    endtask

    task automatic test_basic();
        test_directed("x12_s4_t0", 12, 4, 0, 0, 0, 3, 1'b1, 1'b1, W + 1);
        test_directed("x13_s5_t3", 13, 5, 3, 0, 3, 2, 1'b1, 1'b0, W + 1);
        test_directed("x13_s5_t2", 13, 5, 2, 0, 3, 2, 1'b0, 1'b0, W + 1);
    endtask

    task automatic test_div_zero();
        test_directed("x9_s0_t9", 9, 0, 9, 0, 9, 15, 1'b1, 1'b0, 1);
        test_directed("x0_s0_t1", 0, 0, 1, 0, 0, 15, 1'b0, 1'b1, 1);
    endtask

    task automatic test_backpressure();
        test_directed("backpressure", 15, 1, 3, 4, 0, 15, 1'b0, 1'b1, W + 1);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        bus.in_x     = W'(14);
        bus.in_s     = W'(3);
        bus.in_t     = W'(2);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        test_reset();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_discard: got out_valid pulse want none");
        end
        test_directed("post_reset_x7_s3", 7, 3, 0, 0, 1, 2, 1'b0, 1'b0, W + 1);
    endtask

    task automatic test_sweep();
        bit got, m, z, b_ok, h_ok, a_ok, e_m, e_z;
        int lat, rem, quo, e_rem, e_quo, e_lat;
        for (int x = 0; x < (1 << W); x++) begin
            for (int s = 0; s < (1 << W); s++) begin
                for (int t = 0; t < (1 << W); t++) begin
                    model(x, s, t, e_rem, e_quo, e_m, e_z);
                    e_lat = (s == 0) ? 1 : W + 1;
                    run_txn(x, s, t, $urandom_range(0, 3), got, lat, rem, quo, m, z,
                            b_ok, h_ok, a_ok);
                    n_cmp++;
                    if (!got || lat != e_lat || !b_ok || !h_ok || !a_ok ||
                        rem != e_rem || quo != e_quo || m != e_m || z != e_z) begin
                        n_err++;
                        $display("FAIL sweep x=%0d s=%0d t=%0d: got rem=%0d quo=%0d m=%b z=%b lat=%0d hs=%b%b%b want rem=%0d quo=%0d m=%b z=%b lat=%0d",
                                 x, s, t, rem, quo, m, z, lat, b_ok, h_ok, a_ok,
                                 e_rem, e_quo, e_m, e_z, e_lat);
                    end
                    if (got && $urandom_range(0, 3) == 0) tick();
                end
            end
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_s      = '0;
        bus.in_t      = '0;
        bus.out_ready = 1'b0;
        #2;
        test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        test_basic();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
